// File: rtl/control_unit.sv
// Instruction sequencer: fetches a 9-bit instruction and steps it
// through T0..T3, driving every bus and register-file control line.
module control_unit #(
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic [DW-1:0] din,
  output logic          irin,
  output logic [7:0]    rin,
  output logic [7:0]    rout,
  output logic          gout,
  output logic          dinout,
  output logic          ain,
  output logic          gin,
  output logic          sub,
  output logic          done,
  output logic          busy
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_t     state_q, state_d;
  logic [8:0] ir_q, ir_d;
  logic [2:0] op, rx, ry;
  logic [7:0] x_oh, y_oh;

  logic unused_din;
  assign unused_din = ^din[DW-1:9];

  assign op   = ir_q[8:6];
  assign rx   = ir_q[5:3];
  assign ry   = ir_q[2:0];
  assign x_oh = 8'b1 << rx;
  assign y_oh = 8'b1 << ry;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    irin    = 1'b0;
    rin     = '0;
    rout    = '0;
    gout    = 1'b0;
    dinout  = 1'b0;
    ain     = 1'b0;
    gin     = 1'b0;
    sub     = 1'b0;
    done    = 1'b0;
    busy    = (state_q != T0);
    unique case (state_q)
      T0: begin
        if (run) begin
          irin    = 1'b1;
          state_d = T1;
        end
      end
      T1: begin
        unique case (op)
          OP_MV: begin
            rout    = y_oh;
            rin     = x_oh;
            done    = 1'b1;
            state_d = T0;
          end
          OP_MVI: begin
            dinout  = 1'b1;
            rin     = x_oh;
            done    = 1'b1;
            state_d = T0;
          end
          OP_ADD, OP_SUB: begin
            rout    = x_oh;
            ain     = 1'b1;
            state_d = T2;
          end
          default: begin
            done    = 1'b1;
            state_d = T0;
          end
        endcase
      end
      T2: begin
        rout    = y_oh;
        gin     = 1'b1;
        sub     = (op == OP_SUB);
        state_d = T3;
      end
      T3: begin
        gout    = 1'b1;
        rin     = x_oh;
        done    = 1'b1;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
    // reset silences every strobe, including the fetch in T0
    if (reset) begin
      state_d = T0;
      irin    = 1'b0;
      rin     = '0;
      rout    = '0;
      gout    = 1'b0;
      dinout  = 1'b0;
      ain     = 1'b0;
      gin     = 1'b0;
      sub     = 1'b0;
      done    = 1'b0;
      busy    = 1'b0;
    end
  end

  assign ir_d = irin ? din[8:0] : ir_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] din;
  logic        irin, gout, dinout, ain, gin, sub, done, busy;
  logic [7:0]  rin, rout;
  logic [23:0] outs;

  int checks = 0;
  int fails  = 0;

  control_unit #(.DW(16)) dut (
    .clock(clock), .reset(reset), .run(run), .din(din),
    .irin(irin), .rin(rin), .rout(rout), .gout(gout),
    .dinout(dinout), .ain(ain), .gin(gin), .sub(sub),
    .done(done), .busy(busy)
  );

  always #5 clock = ~clock;

  assign outs = {irin, rin, rout, gout, dinout,
                 ain, gin, sub, done, busy};

  function automatic logic [23:0] ev(
    input logic i, input logic [7:0] ri, input logic [7:0] ro,
    input logic go, input logic di, input logic a,
    input logic g, input logic s, input logic d, input logic b);
    return {i, ri, ro, go, di, a, g, s, d, b};
  endfunction

  // bus-driver and one-hot invariants every cycle
  always @(negedge clock) begin
    checks++;
    if (($countones(rout) + gout + dinout) > 1 ||
        $countones(rin) > 1) begin
      fails++;
      $display("FAIL bus_invariant: rout=%h gout=%b dinout=%b rin=%h",
               rout, gout, dinout, rin);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [23:0] exp);
    #2;
    checks++;
    if (outs !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, outs, exp);
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1; run = 1; din = 16'h0050;
    for (int i = 0; i < 3; i++)
      chk("reset_hold", 24'h0);
    reset = 0; run = 0;
    chk("reset_idle", 24'h0);
  endtask

  task automatic test_mvi_mv();
    run = 1; din = 16'h0040;
    chk("mvi_t0", ev(1,0,0,0,0,0,0,0,0,0));
    run = 0; din = 16'h0005;
    chk("mvi_t1", ev(0,8'h01,0,0,1,0,0,0,1,1));
    run = 1; din = 16'h0008;
    chk("mv_t0", ev(1,0,0,0,0,0,0,0,0,0));
    run = 0;
    chk("mv_t1", ev(0,8'h02,8'h01,0,0,0,0,0,1,1));
    chk("mv_idle", 24'h0);
  endtask

  task automatic test_add();
    run = 1; din = 16'h0093;
    chk("add_t0", ev(1,0,0,0,0,0,0,0,0,0));
    run = 0;
    chk("add_t1", ev(0,0,8'h04,0,0,1,0,0,0,1));
    chk("add_t2", ev(0,0,8'h08,0,0,0,1,0,0,1));
    chk("add_t3", ev(0,8'h04,0,1,0,0,0,0,1,1));
    chk("add_idle", 24'h0);
  endtask

  task automatic test_sub();
    run = 1; din = 16'h00E9;
    chk("sub_t0", ev(1,0,0,0,0,0,0,0,0,0));
    run = 0;
    chk("sub_t1", ev(0,0,8'h20,0,0,1,0,0,0,1));
    chk("sub_t2", ev(0,0,8'h02,0,0,0,1,1,0,1));
    chk("sub_t3", ev(0,8'h20,0,1,0,0,0,0,1,1));
    chk("sub_idle", 24'h0);
  endtask

  task automatic test_same_reg();
    run = 1; din = 16'h001B;
    chk("mv33_t0", ev(1,0,0,0,0,0,0,0,0,0));
    run = 0;
    chk("mv33_t1", ev(0,8'h08,8'h08,0,0,0,0,0,1,1));
  endtask

  task automatic test_back_to_back();
    run = 1; din = 16'h0008;
    chk("b2b_c0", ev(1,0,0,0,0,0,0,0,0,0));
    din = 16'h0000;
    chk("b2b_c1", ev(0,8'h02,8'h01,0,0,0,0,0,1,1));
    din = 16'h0093;
    chk("b2b_c2", ev(1,0,0,0,0,0,0,0,0,0));
    din = 16'h01FF;
    chk("b2b_c3", ev(0,0,8'h04,0,0,1,0,0,0,1));
    chk("b2b_c4", ev(0,0,8'h08,0,0,0,1,0,0,1));
    chk("b2b_c5", ev(0,8'h04,0,1,0,0,0,0,1,1));
    chk("b2b_c6", ev(1,0,0,0,0,0,0,0,0,0));
    run = 0;
    chk("b2b_c7", ev(0,0,0,0,0,0,0,0,1,1));
    chk("b2b_idle", 24'h0);
  endtask

  task automatic test_reset_mid();
    run = 1; din = 16'h0093;
    chk("rst_c0", ev(1,0,0,0,0,0,0,0,0,0));
    run = 0;
    chk("rst_c1", ev(0,0,8'h04,0,0,1,0,0,0,1));
    reset = 1;
    chk("rst_c2", 24'h0);
    reset = 0;
    chk("rst_c3", 24'h0);
    chk("rst_c4", 24'h0);
  endtask

  initial begin
    test_reset();
    test_mvi_mv();
    test_add();
    test_sub();
    test_same_reg();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
